// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH-stage valid/ctrl/data pipeline register with stall, flush and occupancy count.
module pipe_stage_reg #(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 2,
  parameter int DEPTH      = 1,
  parameter int CLEAR_DATA = 0,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DEPTH-1:0]  stage_valid_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o
);
  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][CTRL_W-1:0] r_ctrl;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [CNT_W-1:0]             r_count;
  logic [DEPTH-1:0]             w_nv;
  logic [DEPTH-1:0][CTRL_W-1:0] w_nc;
  logic [DEPTH-1:0][DATA_W-1:0] w_nd;
  logic [CTRL_W-1:0]            w_c0;
  logic [DATA_W-1:0]            w_d0;
  // a bubble entering stage 0 carries no control (and no data when clearing)
  assign w_c0 = valid_i ? ctrl_i : '0;
  assign w_d0 = (CLEAR_DATA != 0 && !valid_i) ? '0 : data_i;
  if (DEPTH > 1) begin : g_deep
    assign w_nv = {r_valid[DEPTH-2:0], valid_i};
    assign w_nc = {r_ctrl[DEPTH-2:0], w_c0};
    assign w_nd = {r_data[DEPTH-2:0], w_d0};
  end else begin : g_one
    assign w_nv = valid_i;
    assign w_nc = w_c0;
    assign w_nd = w_d0;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= '0;
      r_ctrl  <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
      r_ctrl  <= '0;
      r_data  <= CLEAR_DATA != 0 ? '0 : r_data;
      r_count <= '0;
    end else if (!stall_i) begin
      r_valid <= w_nv;
      r_ctrl  <= w_nc;
      r_data  <= w_nd;
      r_count <= r_count + CNT_W'(valid_i) - CNT_W'(r_valid[DEPTH-1]);
    end
  end
  assign valid_o       = r_valid[DEPTH-1];
  assign data_o        = r_data[DEPTH-1];
  assign ctrl_o        = r_ctrl[DEPTH-1];
  assign stage_valid_o = r_valid;
  assign count_o       = r_count;
  assign empty_o       = r_count == '0;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: three configurations driven in parallel and checked every cycle against an entry-array model.
module tb_pipe_stage_reg;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        valid_i = 0, stall_i = 0, flush_i = 0;
  logic [68:0] data_i = '0;
  logic [1:0]  ctrl_i = '0;
  always #5 clk = ~clk;

  logic        v0, v1, v2, e0, e1, e2;
  logic [63:0] d0, d1;
  logic [68:0] d2;
  logic [1:0]  c0, c1, c2, n0, n1;
  logic [2:0]  sv0, sv1;
  logic        sv2, n2;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(2), .DEPTH(3), .CLEAR_DATA(0)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .data_i(data_i[63:0]), .ctrl_i(ctrl_i),
    .stall_i(stall_i), .flush_i(flush_i), .valid_o(v0), .data_o(d0), .ctrl_o(c0),
    .stage_valid_o(sv0), .count_o(n0), .empty_o(e0));
  pipe_stage_reg #(.DATA_W(64), .CTRL_W(2), .DEPTH(3), .CLEAR_DATA(1)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .data_i(data_i[63:0]), .ctrl_i(ctrl_i),
    .stall_i(stall_i), .flush_i(flush_i), .valid_o(v1), .data_o(d1), .ctrl_o(c1),
    .stage_valid_o(sv1), .count_o(n1), .empty_o(e1));
  pipe_stage_reg #(.DATA_W(69), .CTRL_W(2), .DEPTH(1), .CLEAR_DATA(0)) u2 (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .data_i(data_i), .ctrl_i(ctrl_i),
    .stall_i(stall_i), .flush_i(flush_i), .valid_o(v2), .data_o(d2), .ctrl_o(c2),
    .stage_valid_o(sv2), .count_o(n2), .empty_o(e2));

  int dep[3] = '{3, 3, 1};
  bit cdat[3] = '{0, 1, 0};
  int dwid[3] = '{64, 64, 69};
  bit           m_v[3][8];
  logic [1:0]   m_c[3][8];
  logic [127:0] m_d[3][8];
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int u = 0; u < 3; u++)
      for (int k = 0; k < 8; k++) begin
        m_v[u][k] = 0; m_c[u][k] = 0; m_d[u][k] = 0;
      end
  endtask

  task automatic m_step();
    for (int u = 0; u < 3; u++) begin
      logic [127:0] mask = (128'd1 << dwid[u]) - 1;
      if (flush_i) begin
        for (int k = 0; k < dep[u]; k++) begin
          m_v[u][k] = 0; m_c[u][k] = 0;
          if (cdat[u]) m_d[u][k] = 0;
        end
      end else if (!stall_i) begin
        for (int k = dep[u] - 1; k > 0; k--) begin
          m_v[u][k] = m_v[u][k-1]; m_c[u][k] = m_c[u][k-1]; m_d[u][k] = m_d[u][k-1];
        end
        m_v[u][0] = valid_i;
        m_c[u][0] = valid_i ? ctrl_i : 2'b00;
        m_d[u][0] = (cdat[u] && !valid_i) ? 128'd0 : (128'(data_i) & mask);
      end
    end
  endtask

  function automatic int m_cnt(input int u);
    int n = 0;
    for (int k = 0; k < dep[u]; k++) n += int'(m_v[u][k]);
    return n;
  endfunction

  function automatic logic [7:0] m_sv(input int u);
    logic [7:0] s = '0;
    for (int k = 0; k < dep[u]; k++) s[k] = m_v[u][k];
    return s;
  endfunction

  task automatic check_all();
    chk("u0_valid", v0, m_v[0][2]);  chk("u0_ctrl", c0, m_c[0][2]);
    chk("u0_data", d0, m_d[0][2]);   chk("u0_sv", sv0, m_sv(0));
    chk("u0_cnt", n0, m_cnt(0));     chk("u0_empty", e0, m_cnt(0) == 0);
    chk("u0_popc", n0, $countones(sv0));
    chk("u1_valid", v1, m_v[1][2]);  chk("u1_ctrl", c1, m_c[1][2]);
    chk("u1_data", d1, m_d[1][2]);   chk("u1_sv", sv1, m_sv(1));
    chk("u1_cnt", n1, m_cnt(1));     chk("u1_empty", e1, m_cnt(1) == 0);
    chk("u2_valid", v2, m_v[2][0]);  chk("u2_ctrl", c2, m_c[2][0]);
    chk("u2_data", d2, m_d[2][0]);   chk("u2_sv", sv2, m_sv(2));
    chk("u2_cnt", n2, m_cnt(2));     chk("u2_empty", e2, m_cnt(2) == 0);
  endtask

  task automatic cyc(input logic v, input logic [68:0] d, input logic [1:0] c,
                     input logic s, input logic f);
    valid_i = v; data_i = d; ctrl_i = c; stall_i = s; flush_i = f;
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic reset_mid();
    @(posedge clk);
    m_step();
    #2 rst_n = 0;
    #1 m_reset();
    check_all();
    chk("rst_async_empty", {e0, e1, e2}, 3'b111);
    @(negedge clk);
    rst_n = 1;
    check_all();
  endtask

  function automatic logic [68:0] rnd69();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    m_reset();
    #12 check_all();
    @(negedge clk) rst_n = 1;
    // single entry latency
    cyc(1, 69'h0000_0005_0000_0007, 2'b11, 0, 0);
    chk("lat_cnt1", n0, 1);
    cyc(0, '0, 2'b00, 0, 0);
    cyc(0, '0, 2'b00, 0, 0);
    chk("lat3_valid", v0, 1);
    chk("lat3_data", d0, 64'h0000_0005_0000_0007);
    cyc(0, '0, 2'b00, 0, 0);
    chk("lat_drained", n0, 0);
    // stall hold
    cyc(1, 69'hA, 2'b01, 0, 0);
    cyc(1, 69'hB, 2'b10, 0, 0);
    cyc(1, 69'hC, 2'b11, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, rnd69(), 2'b10, 1, 0);
    chk("stall_sv", sv0, 3'b111);
    chk("stall_cnt", n0, 3);
    cyc(1, 69'hD, 2'b01, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, '0, 2'b00, 0, 0);
    // flush beats stall
    for (int i = 0; i < 3; i++) cyc(1, rnd69(), 2'(i + 1), 0, 0);
    cyc(1, rnd69(), 2'b11, 1, 1);
    chk("flush_sv", sv0, 3'b000);
    chk("flush_empty", e0, 1);
    // asynchronous reset during a stall
    for (int i = 0; i < 3; i++) cyc(1, rnd69(), 2'b11, 0, 0);
    valid_i = 1; stall_i = 1;
    reset_mid();
    // bubbles with hostile inputs
    for (int i = 0; i < 5; i++) cyc(0, '1, 2'b11, 0, 0);
    chk("bubble_data", d1, 64'd0);
    // steady stream
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 5; i++) cyc((5'b01101 >> i) & 1'b1, 69'(r * 5 + i + 1), 2'(i), 0, 0);
    // random traffic
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(2) != 0, rnd69(), 2'($urandom), $urandom_range(4) == 0,
          $urandom_range(15) == 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
